// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel state encoding
// and the default settle time for the 50 MHz board clock.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  // 20 ms worth of 50 MHz clock cycles
  localparam int DEFAULT_STABLE_CYCLES = 50_000_000 / 50;

endpackage

// File: rtl/db_channel.sv
// One debounced button: two-flop synchronizer feeding a settle-time FSM that
// emits a registered level plus single-cycle press/release pulses.
module db_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db_level,
  output logic db_press,
  output logic db_release
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // raw is asynchronous to clk, so only s2 is allowed to reach the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any s2 change during a WAIT state drops back to the previous stable state,
  // so the counter always measures one uninterrupted run of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOW;
      cnt        <= '0;
      db_level   <= 1'b0;
      db_press   <= 1'b0;
      db_release <= 1'b0;
    end else begin
      db_press   <= 1'b0;
      db_release <= 1'b0;
      case (state)
        S_LOW: begin
          if (s2) begin
            state <= S_WAIT_HI;
            cnt   <= '0;
          end
        end
        S_WAIT_HI: begin
          if (!s2) begin
            state <= S_LOW;
          end else if (cnt == CNT_LAST) begin
            state    <= S_HIGH;
            db_level <= 1'b1;
            db_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!s2) begin
            state <= S_WAIT_LO;
            cnt   <= '0;
          end
        end
        S_WAIT_LO: begin
          if (s2) begin
            state <= S_HIGH;
          end else if (cnt == CNT_LAST) begin
            state      <= S_LOW;
            db_level   <= 1'b0;
            db_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// N independent debounced button channels; each bit of the output buses comes
// from its own db_channel instance.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_press,
  output logic [N_CH-1:0] db_release
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw[i]),
      .db_level  (db_level[i]),
      .db_press  (db_press[i]),
      .db_release(db_release[i])
    );
  end

endmodule
